// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared byte width and packed-vector slicing helpers for the register bank
package reg_bank_pkg;
    localparam int BYTE_W = 8;
    function automatic int strb_w(input int width);
        return width / BYTE_W;
    endfunction
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction
endpackage

// File: rtl/reg_byte_merge.sv
// reg_byte_merge: prioritised byte-strobe merge of all write ports into one register word
module reg_byte_merge
    import reg_bank_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_WR = 2,
    parameter int AW     = 3,
    parameter int IDX    = 0
) (
    input  logic [WIDTH-1:0]                cur,
    input  logic [NUM_WR-1:0]               wr_en,
    input  logic [NUM_WR*AW-1:0]            wr_addr,
    input  logic [NUM_WR*WIDTH-1:0]         wr_data,
    input  logic [NUM_WR*strb_w(WIDTH)-1:0] wr_strb,
    output logic [WIDTH-1:0]                nxt,
    output logic                            hit
);
    localparam int SW = strb_w(WIDTH);

    always_comb begin
        nxt = cur;
        hit = 1'b0;
        for (int p = NUM_WR - 1; p >= 0; p--) begin
            if (wr_en[p] && wr_addr[slice_lo(p, AW) +: AW] == AW'(IDX)) begin
                hit = hit | (|wr_strb[slice_lo(p, SW) +: SW]);
                for (int b = 0; b < SW; b++)
                    if (wr_strb[slice_lo(p, SW) + b])
                        nxt[b*BYTE_W +: BYTE_W] = wr_data[slice_lo(p, WIDTH) + b*BYTE_W +: BYTE_W];
            end
        end
    end
endmodule

// File: rtl/reg_bank_rw.sv
// reg_bank_rw: multi-port register bank with shadow/active double-buffering and a registered read port
module reg_bank_rw
    import reg_bank_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int NUM_WR = 2,
    parameter int SHADOW = 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_WR-1:0]               wr_en,
    input  logic [NUM_WR*AW-1:0]            wr_addr,
    input  logic [NUM_WR*WIDTH-1:0]         wr_data,
    input  logic [NUM_WR*strb_w(WIDTH)-1:0] wr_strb,
    input  logic                            commit,
    input  logic                            rd_en,
    input  logic [AW-1:0]                   rd_addr,
    input  logic                            rd_shadow,
    output logic [WIDTH-1:0]                rd_data,
    output logic                            rd_valid,
    output logic [DEPTH*WIDTH-1:0]          q_active,
    output logic                            pending,
    output logic                            addr_err
);
    logic [WIDTH-1:0] active_q [DEPTH];
    logic [WIDTH-1:0] active_d [DEPTH];
    logic [WIDTH-1:0] shadow_q [DEPTH];
    logic [WIDTH-1:0] shadow_d [DEPTH];
    logic [WIDTH-1:0] merged [DEPTH];
    logic [DEPTH-1:0] hit_vec;
    logic [WIDTH-1:0] rd_data_q, rd_data_d, rd_word;
    logic             rd_valid_q, rd_valid_d;
    logic             pending_q, pending_d;
    logic             addr_err_q, addr_err_d;
    logic             wr_oob;

    // widened compare keeps the range check meaningful when DEPTH is a power of two
    function automatic logic oob(input logic [AW-1:0] a);
        return {1'b0, a} >= (AW+1)'(DEPTH);
    endfunction

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        reg_byte_merge #(
            .WIDTH  (WIDTH),
            .NUM_WR (NUM_WR),
            .AW     (AW),
            .IDX    (g)
        ) u_merge (
            .cur     (SHADOW != 0 ? shadow_q[g] : active_q[g]),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .wr_strb (wr_strb),
            .nxt     (merged[g]),
            .hit     (hit_vec[g])
        );
        assign q_active[g*WIDTH +: WIDTH] = active_q[g];
    end

    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            shadow_d[r] = SHADOW != 0 ? merged[r] : '0;
            active_d[r] = (SHADOW == 0 || commit) ? merged[r] : active_q[r];
        end
        wr_oob = 1'b0;
        for (int p = 0; p < NUM_WR; p++)
            wr_oob = wr_oob | (wr_en[p] && oob(wr_addr[slice_lo(p, AW) +: AW]));
        pending_d  = SHADOW != 0 && !commit && (pending_q || |hit_vec);
        addr_err_d = addr_err_q || wr_oob || (rd_en && oob(rd_addr));
        rd_word    = oob(rd_addr) ? '0 :
                     (rd_shadow && SHADOW != 0) ? shadow_q[rd_addr] : active_q[rd_addr];
        rd_data_d  = rd_en ? rd_word : rd_data_q;
        rd_valid_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q   <= '{default: '0};
            shadow_q   <= '{default: '0};
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            pending_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            pending_q  <= pending_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign pending  = pending_q;
    assign addr_err = addr_err_q;
endmodule

// File: tb/tb_reg_bank_rw.sv
// tb_reg_bank_rw: directed checks of a shadowed 8-deep bank and a direct-write 6-deep bank
module tb_reg_bank_rw;
    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   wr_en;
    logic [5:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [7:0]   wr_strb;
    logic         commit, rd_en, rd_shadow;
    logic [2:0]   rd_addr;
    logic [31:0]  rd_data_a, rd_data_b;
    logic         rd_valid_a, rd_valid_b, pending_a, pending_b, addr_err_a, addr_err_b;
    logic [255:0] q_active_a;
    logic [191:0] q_active_b;
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    reg_bank_rw #(.WIDTH(32), .DEPTH(8), .NUM_WR(2), .SHADOW(1)) u_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .commit(commit), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_shadow(rd_shadow), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .q_active(q_active_a), .pending(pending_a), .addr_err(addr_err_a)
    );

    reg_bank_rw #(.WIDTH(32), .DEPTH(6), .NUM_WR(2), .SHADOW(0)) u_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .commit(commit), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_shadow(rd_shadow), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .q_active(q_active_b), .pending(pending_b), .addr_err(addr_err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        commit = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_shadow = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en[p] = 1'b1; wr_addr[p*3 +: 3] = a; wr_data[p*32 +: 32] = d; wr_strb[p*4 +: 4] = s;
    endtask

    task automatic set_rd(input logic [2:0] a, input logic sh);
        rd_en = 1'b1; rd_addr = a; rd_shadow = sh;
    endtask

    task automatic test_reset();
        idle(); reset = 1'b0; tick(); tick(); idle();
        checks++; if (q_active_a !== '0) $display("FAIL reset_q_a got %h want 0", q_active_a); else passes++;
        checks++; if (q_active_b !== '0) $display("FAIL reset_q_b got %h want 0", q_active_b); else passes++;
        checks++; if ({rd_data_a, rd_valid_a, pending_a, addr_err_a} !== '0)
            $display("FAIL reset_flags_a got %h/%b/%b/%b want 0", rd_data_a, rd_valid_a, pending_a, addr_err_a); else passes++;
    endtask

    task automatic test_shadow_commit();
        set_wr(0, 3'd3, 32'hDEADBEEF, 4'hF); tick(); idle();
        set_rd(3'd3, 1'b0); tick();
        checks++; if (rd_data_a !== 32'h0 || rd_valid_a !== 1'b1)
            $display("FAIL sc_read_active got %h/%b want 00000000/1", rd_data_a, rd_valid_a); else passes++;
        set_rd(3'd3, 1'b1); tick();
        checks++; if (rd_data_a !== 32'hDEADBEEF) $display("FAIL sc_read_shadow got %h want deadbeef", rd_data_a); else passes++;
        checks++; if (pending_a !== 1'b1) $display("FAIL sc_pending_set got %b want 1", pending_a); else passes++;
        idle(); commit = 1'b1; tick(); idle();
        checks++; if (pending_a !== 1'b0) $display("FAIL sc_pending_clr got %b want 0", pending_a); else passes++;
        checks++; if (q_active_a[3*32 +: 32] !== 32'hDEADBEEF)
            $display("FAIL sc_q_active got %h want deadbeef", q_active_a[3*32 +: 32]); else passes++;
        set_rd(3'd3, 1'b0); tick(); idle();
        checks++; if (rd_data_a !== 32'hDEADBEEF) $display("FAIL sc_read_commit got %h want deadbeef", rd_data_a); else passes++;
        tick();
        checks++; if (rd_valid_a !== 1'b0 || rd_data_a !== 32'hDEADBEEF)
            $display("FAIL sc_read_hold got %h/%b want deadbeef/0", rd_data_a, rd_valid_a); else passes++;
    endtask

    task automatic test_merge();
        set_wr(0, 3'd1, 32'h11111111, 4'h3); set_wr(1, 3'd1, 32'h22222222, 4'hF); tick(); idle();
        set_rd(3'd1, 1'b1); tick(); idle();
        checks++; if (rd_data_a !== 32'h22221111) $display("FAIL merge_partial got %h want 22221111", rd_data_a); else passes++;
        set_wr(0, 3'd1, 32'h11111111, 4'hF); set_wr(1, 3'd1, 32'h22222222, 4'hF); tick(); idle();
        set_rd(3'd1, 1'b1); tick(); idle();
        checks++; if (rd_data_a !== 32'h11111111) $display("FAIL merge_full got %h want 11111111", rd_data_a); else passes++;
        set_wr(0, 3'd1, 32'hFFFFFFFF, 4'h0); set_wr(1, 3'd1, 32'h00000033, 4'h1); tick(); idle();
        set_rd(3'd1, 1'b1); tick(); idle();
        checks++; if (rd_data_a !== 32'h11111133) $display("FAIL merge_zero_strb got %h want 11111133", rd_data_a); else passes++;
    endtask

    task automatic test_write_commit();
        set_wr(0, 3'd2, 32'h000000AA, 4'hF); commit = 1'b1; tick(); idle();
        checks++; if (q_active_a[2*32 +: 32] !== 32'h000000AA)
            $display("FAIL wc_q_reg2 got %h want 000000aa", q_active_a[2*32 +: 32]); else passes++;
        checks++; if (q_active_a[1*32 +: 32] !== 32'h11111133)
            $display("FAIL wc_q_reg1 got %h want 11111133", q_active_a[1*32 +: 32]); else passes++;
        checks++; if (pending_a !== 1'b0) $display("FAIL wc_pending got %b want 0", pending_a); else passes++;
    endtask

    task automatic test_reset_dominates();
        set_wr(0, 3'd4, 32'h12345678, 4'hF); set_wr(1, 3'd5, 32'hCAFEF00D, 4'hF); tick(); idle();
        commit = 1'b1; tick(); idle();
        set_rd(3'd4, 1'b0); tick();
        checks++; if (rd_data_a !== 32'h12345678) $display("FAIL rd_pre_reset got %h want 12345678", rd_data_a); else passes++;
        set_wr(0, 3'd6, 32'h77777777, 4'hF); set_wr(1, 3'd7, 32'h88888888, 4'hF);
        commit = 1'b1; reset = 1'b0; tick(); idle();
        checks++; if (q_active_a !== '0 || q_active_b !== '0)
            $display("FAIL rd_q_zero got %h / %h want 0", q_active_a, q_active_b); else passes++;
        checks++; if ({rd_data_a, rd_valid_a, pending_a, addr_err_a} !== '0)
            $display("FAIL rd_flags_a got %h/%b/%b/%b want 0", rd_data_a, rd_valid_a, pending_a, addr_err_a); else passes++;
        set_rd(3'd6, 1'b1); tick(); idle();
        checks++; if (rd_data_a !== 32'h0 || pending_a !== 1'b0)
            $display("FAIL rd_writes_lost got %h/%b want 0/0", rd_data_a, pending_a); else passes++;
    endtask

    task automatic test_direct();
        set_wr(0, 3'd0, 32'h5A5A5A5A, 4'hF); tick(); idle();
        checks++; if (q_active_b[31:0] !== 32'h5A5A5A5A) $display("FAIL dir_q got %h want 5a5a5a5a", q_active_b[31:0]); else passes++;
        checks++; if (pending_b !== 1'b0 || pending_a !== 1'b1)
            $display("FAIL dir_pending got b=%b a=%b want 0/1", pending_b, pending_a); else passes++;
        commit = 1'b1; tick(); idle();
        checks++; if (q_active_b !== 192'h5A5A5A5A || pending_b !== 1'b0)
            $display("FAIL dir_commit got %h/%b want 5a5a5a5a/0", q_active_b, pending_b); else passes++;
        set_rd(3'd0, 1'b1); tick(); idle();
        checks++; if (rd_data_b !== 32'h5A5A5A5A) $display("FAIL dir_rd_shadow got %h want 5a5a5a5a", rd_data_b); else passes++;
    endtask

    task automatic test_oob();
        set_wr(0, 3'd7, 32'hFFFFFFFF, 4'hF); tick(); idle();
        checks++; if (q_active_b !== 192'h5A5A5A5A) $display("FAIL oob_q got %h want 5a5a5a5a", q_active_b); else passes++;
        checks++; if (addr_err_b !== 1'b1 || addr_err_a !== 1'b0)
            $display("FAIL oob_err got b=%b a=%b want 1/0", addr_err_b, addr_err_a); else passes++;
        set_rd(3'd7, 1'b0); tick(); idle();
        checks++; if (rd_data_b !== 32'h0 || rd_valid_b !== 1'b1)
            $display("FAIL oob_read got %h/%b want 00000000/1", rd_data_b, rd_valid_b); else passes++;
        tick();
        checks++; if (addr_err_b !== 1'b1) $display("FAIL oob_sticky got %b want 1", addr_err_b); else passes++;
    endtask

    initial begin
        idle();
        test_reset();
        test_shadow_commit();
        test_merge();
        test_write_commit();
        test_reset_dominates();
        test_direct();
        test_oob();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
